// File: rtl/fb_scanout.sv
`default_nettype none
// =============================================================================
// fb_scanout : VGA raster timing and frame-buffer scan-out, syncs aligned to data
// Rev 1.0
// =============================================================================
module fb_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int ADDR_W   = 19,
    parameter int PIX_W    = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [HW-1:0]     h_cnt, h_nxt;
    logic [VW-1:0]     v_cnt, v_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;

    logic running, de, hs_act, vs_act, first_px;
    logic de_d1, hs_d1, vs_d1, fs_d1;

    // Stage 0: raster position and the address of the pixel being read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
            addr  <= '0;
        end else begin
            state <= state_nxt;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            addr  <= addr_nxt;
        end
    end

    // The first enabled edge only arms the raster at (0,0); counting starts after.
    always_comb begin
        state_nxt = state;
        h_nxt     = '0;
        v_nxt     = '0;
        addr_nxt  = '0;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_RUN;
                ST_RUN: begin
                    h_nxt = (h_cnt == H_LAST) ? '0 : h_cnt + HW'(1);
                    if (h_cnt == H_LAST)
                        v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
                    else
                        v_nxt = v_cnt;
                    // Advance only when stepping onto an active pixel so blanking holds the last address
                    if (h_nxt == '0 && v_nxt == '0)
                        addr_nxt = '0;
                    else if (h_nxt < H_ACT && v_nxt < V_ACT)
                        addr_nxt = addr + ADDR_W'(1);
                    else
                        addr_nxt = addr;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign running  = (state == ST_RUN);
    assign de       = running && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_act   = running && (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
    assign vs_act   = running && (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
    assign first_px = running && (h_cnt == '0) && (v_cnt == '0);

    assign rd_en   = de;
    assign rd_addr = addr;

    // Stage 1 pairs control with the frame buffer's registered read; stage 2 drives the pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_d1       <= 1'b0;
            hs_d1       <= 1'b0;
            vs_d1       <= 1'b0;
            fs_d1       <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            frame_start <= 1'b0;
        end else if (!enable) begin
            de_d1       <= 1'b0;
            hs_d1       <= 1'b0;
            vs_d1       <= 1'b0;
            fs_d1       <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            de_d1       <= de;
            hs_d1       <= hs_act;
            vs_d1       <= vs_act;
            fs_d1       <= first_px;
            vga_r       <= de_d1 ? rd_data[11:8] : 4'h0;
            vga_g       <= de_d1 ? rd_data[7:4]  : 4'h0;
            vga_b       <= de_d1 ? rd_data[3:0]  : 4'h0;
            vga_hs      <= ~hs_d1;
            vga_vs      <= ~vs_d1;
            frame_start <= fs_d1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout.sv
`default_nettype none
// =============================================================================
// tb_fb_scanout : scoreboard bench for fb_scanout on a reduced raster
// Rev 1.0
// =============================================================================
module tb_fb_scanout;

    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 8,  VFP = 1, VS = 2, VBP = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic        en;
        logic [18:0] addr;
        logic [11:0] pix;
        logic        hs;
        logic        vs;
        logic        fs;
    } exp_t;

    logic        clk, rst_n, enable;
    logic        rd_en;
    logic [18:0] rd_addr;
    logic [11:0] rd_data;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, frame_start;

    int vectors = 0, miscompares = 0;

    fb_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .ADDR_W(19), .PIX_W(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame buffer with 1-clk read latency, preloaded mem[a] = a[11:0]
    always @(posedge clk) if (rd_en) rd_data <= rd_addr[11:0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Raster model and scoreboard
    exp_t q[$];
    bit   m_run;
    int   m_h, m_v;

    function automatic exp_t s0(bit run, int h, int v);
        exp_t e;
        e.en = run && h < HA && v < VA;
        if (!run)         e.addr = 19'd0;
        else if (v >= VA) e.addr = 19'(HA * VA - 1);
        else if (h >= HA) e.addr = 19'(v * HA + HA - 1);
        else              e.addr = 19'(v * HA + h);
        e.pix = e.en ? e.addr[11:0] : 12'h0;
        e.hs  = !(run && h >= HA + HFP && h < HA + HFP + HS);
        e.vs  = !(run && v >= VA + VFP && v < VA + VFP + VS);
        e.fs  = run && h == 0 && v == 0;
        return e;
    endfunction

    function automatic logic [14:0] pins();
        return {vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start};
    endfunction

    task automatic reset_model();
        m_run = 0; m_h = 0; m_v = 0;
        q.delete();
        repeat (3) q.push_back(s0(0, 0, 0));
    endtask

    // Pin-level timing statistics
    bit stats_on, fs_seen, rd_seen, hs_prev, vs_prev;
    int cyc, hs_run, vs_run, rd_cnt;

    task automatic stats_clear();
        fs_seen = 0; rd_seen = 0; hs_prev = 1; vs_prev = 1;
        cyc = 0; hs_run = 0; vs_run = 0; rd_cnt = 0;
    endtask

    task automatic stats();
        if (frame_start) begin
            if (fs_seen) check("fs_period", cyc + 1, FRAME);
            fs_seen = 1; cyc = 0;
        end else cyc++;
        if (fs_seen) begin
            if (!vga_hs && hs_prev) check("hs_start", cyc % HT, HA + HFP);
            if (!vga_hs) hs_run++;
            else if (hs_run > 0) begin check("hs_width", hs_run, HS); hs_run = 0; end
            if (!vga_vs && vs_prev) check("vs_start", cyc, (VA + VFP) * HT);
            if (!vga_vs) vs_run++;
            else if (vs_run > 0) begin check("vs_width", vs_run, VS * HT); vs_run = 0; end
        end
        hs_prev = vga_hs; vs_prev = vga_vs;
        if (rd_en && rd_addr == 19'd0) begin
            if (rd_seen) check("reads_per_frame", rd_cnt, HA * VA);
            rd_seen = 1; rd_cnt = 0;
        end
        if (rd_en) rd_cnt++;
    endtask

    // One clock: push stage-0 expectation at the edge, compare at the falling edge
    task automatic tick();
        @(posedge clk);
        if (!rst_n || !enable) reset_model();
        else begin
            if (!m_run) begin m_run = 1; m_h = 0; m_v = 0; end
            else begin
                m_h++;
                if (m_h == HT) begin m_h = 0; m_v++; if (m_v == VT) m_v = 0; end
            end
            q.push_back(s0(m_run, m_h, m_v));
            if (q.size() > 3) void'(q.pop_front());
        end
        @(negedge clk);
        check("bus", {rd_en, rd_addr}, {q[$].en, q[$].addr});
        check("pins", pins(), {q[0].pix, q[0].hs, q[0].vs, q[0].fs});
        if (stats_on) stats();
    endtask

    task automatic wait_pos(input int h, input int v);
        int n = 0;
        while (!(m_run && m_h == h && m_v == v) && n < 2 * FRAME) begin tick(); n++; end
        check("wait_bound", 32'(n < 2 * FRAME), 1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; enable = 1'b1; stats_on = 0;
        stats_clear();
        reset_model();
        repeat (3) tick();
        check("rst_bus", {rd_en, rd_addr}, 0);
        check("rst_pins", pins(), 15'h0006);
        rst_n = 1'b1;
        tick();
        check("rst_release_bus", {rd_en, rd_addr}, 20'h80000);

        stats_on = 1;
        repeat (3 * FRAME) tick();
        stats_on = 0;

        // Enable drop mid-frame, re-enable after 50 clocks
        wait_pos(10, 5);
        enable = 1'b0;
        tick();
        check("drop_idle", {rd_en, vga_r, vga_g, vga_b, vga_hs, vga_vs}, 15'h0003);
        repeat (49) tick();
        enable = 1'b1;
        tick();
        check("reenable_bus", {rd_en, rd_addr}, 20'h80000);
        n = 1;
        while (!frame_start && n < 10) begin tick(); n++; end
        check("fs_after_enable", n, 3);
        repeat (FRAME) tick();

        // Asynchronous reset between edges, then one clean frame and more
        wait_pos(5, 4);
        #2 rst_n = 1'b0;
        reset_model();
        #1;
        check("rst_async_bus", {rd_en, rd_addr}, 0);
        check("rst_async_pins", pins(), 15'h0006);
        repeat (2) tick();
        rst_n = 1'b1;
        stats_clear();
        stats_on = 1;
        repeat (2 * FRAME + 4) tick();
        stats_on = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
